pc_lut_loader: RTL and testbench

- Writer side of the 16-entry branch-target LUT. At boot it accepts a byte stream of (index, target) records through a valid/ready handshake, decodes each record and writes the target into a 16x12 table.
- The loaded table is exposed through the same combinational read port the fetch stage uses (4-bit addr in, D-bit target out).
- It replaces testbench-side LUT initialisation in the final design.

---
 rtl/pc_lut_pkg.sv | 15 +
 rtl/pc_lut_loader_if.sv | 11 +
 rtl/pc_lut_store.sv | 32 +++
 rtl/pc_lut_loader.sv | 94 +++++++++
 tb/tb_pc_lut_loader.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_lut_pkg.sv
// rtl/pc_lut_pkg.sv - shared types and constants for the branch-target LUT loader
package pc_lut_pkg;

    localparam int LUT_DEPTH = 16;
    localparam int LUT_IDX_W = 4;
    localparam int REC_TGT_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/pc_lut_loader_if.sv
// rtl/pc_lut_loader_if.sv - byte-stream handshake carrying (index, target) records
interface pc_lut_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/pc_lut_store.sv
// rtl/pc_lut_store.sv - 16xD register file, synchronous write, asynchronous read
module pc_lut_store
    import pc_lut_pkg::*;
#(
    parameter int D = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [LUT_IDX_W-1:0] waddr_i,
    input  logic [D-1:0]         wdata_i,
    input  logic [LUT_IDX_W-1:0] raddr_i,
    output logic [D-1:0]         rdata_o
);

    logic [D-1:0] mem_q [LUT_DEPTH];

    // Clear wins over a same-cycle write so an aborted load never leaves a stray entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < LUT_DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_lut_loader.sv
// rtl/pc_lut_loader.sv - decodes two-byte records from a byte stream into the branch-target LUT
module pc_lut_loader
    import pc_lut_pkg::*;
#(
    parameter int D         = 12,
    parameter int N_ENTRIES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    pc_lut_loader_if.slave       in_if,
    input  logic [LUT_IDX_W-1:0] addr,
    output logic [D-1:0]         target,
    output logic                 loaded,
    output logic                 busy,
    output logic                 dup_err
);

    loader_state_t            state_q, state_d;
    logic [LUT_IDX_W-1:0]     idx_q;
    logic [3:0]               hi_q;
    logic [4:0]               count_q;
    logic [LUT_DEPTH-1:0]     bitmap_q;
    logic                     dup_q;
    logic                     ready;
    logic                     xfer;
    logic                     wr_en;
    logic [REC_TGT_W-1:0]     rec_tgt;

    // start outranks any byte offered in the same cycle.
    assign xfer    = in_if.in_valid && ready && !start;
    assign wr_en   = xfer && (state_q == LO);
    assign rec_tgt = {hi_q, in_if.in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = HI;
        end else begin
            case (state_q)
                HI:      if (xfer) state_d = LO;
                LO:      if (xfer) state_d = (count_q == 5'(N_ENTRIES - 1)) ? DONE : HI;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        ready  = (state_q == HI) || (state_q == LO);
        busy   = ready;
        loaded = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            hi_q     <= '0;
            count_q  <= '0;
            bitmap_q <= '0;
            dup_q    <= 1'b0;
        end else if (start) begin
            count_q  <= '0;
            bitmap_q <= '0;
            dup_q    <= 1'b0;
        end else if (xfer && state_q == HI) begin
            idx_q <= in_if.in_data[7:4];
            hi_q  <= in_if.in_data[3:0];
        end else if (wr_en) begin
            bitmap_q[idx_q] <= 1'b1;
            if (bitmap_q[idx_q]) dup_q <= 1'b1;
            count_q <= count_q + 5'd1;
        end
    end

    assign in_if.in_ready = ready;
    assign dup_err        = dup_q;

    pc_lut_store #(.D(D)) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start),
        .we_i    (wr_en),
        .waddr_i (idx_q),
        .wdata_i (rec_tgt[D-1:0]),
        .raddr_i (addr),
        .rdata_o (target)
    );

endmodule

// File: tb/tb_pc_lut_loader.sv
// tb/tb_pc_lut_loader.sv - randomized directed bench for pc_lut_loader against a record-level table model
module tb_pc_lut_loader;

    localparam int D = 12;
    localparam int N = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [3:0]    addr;
    logic [D-1:0]  target;
    logic          loaded;
    logic          busy;
    logic          dup_err;

    pc_lut_loader_if bus ();

    pc_lut_loader #(.D(D), .N_ENTRIES(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_if   (bus),
        .addr    (addr),
        .target  (target),
        .loaded  (loaded),
        .busy    (busy),
        .dup_err (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [11:0] m_tab [16];
    bit          m_wr  [16];
    bit          m_dup;
    int          m_cnt;

    logic [3:0]  r_idx [16];
    logic [11:0] r_tgt [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_tab[i] = '0;
            m_wr[i]  = 1'b0;
        end
        m_dup = 1'b0;
        m_cnt = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        m_clear();
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            chk(tag, 32'(target), 32'(m_tab[i][D-1:0]));
        end
    endtask

    // Present a byte after some idle cycles and wait (bounded) until it can transfer.
    task automatic offer(input logic [7:0] b, input int gaps, output int waited);
        for (int g = 0; g < gaps; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic send_rec(input logic [3:0] idx, input logic [11:0] tgt,
                            input int maxgap, input bit stall_chk);
        int w0, w1;
        offer({idx, tgt[11:8]}, (maxgap > 0) ? $urandom_range(maxgap, 0) : 0, w0);
        @(negedge clk);
        offer(tgt[7:0], (maxgap > 0) ? $urandom_range(maxgap, 0) : 0, w1);
        addr = idx;
        #1;
        chk("no_bypass", 32'(target), 32'(m_tab[idx][D-1:0]));
        @(negedge clk);
        if (m_wr[idx]) m_dup = 1'b1;
        m_wr[idx]  = 1'b1;
        m_tab[idx] = tgt;
        m_cnt++;
        #1;
        chk("write_latency", 32'(target), 32'(tgt[D-1:0]));
        chk("dup_err", 32'(dup_err), 32'(m_dup));
        chk("loaded", 32'(loaded), 32'(m_cnt >= N));
        if (stall_chk) chk("ready_stall", 32'(w0 + w1), 32'd0);
    endtask

    task automatic shuffle_idx();
        for (int i = 0; i < 16; i++) r_idx[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            int j;
            logic [3:0] t;
            j = $urandom_range(i, 0);
            t = r_idx[i];
            r_idx[i] = r_idx[j];
            r_idx[j] = t;
        end
    endtask

    initial begin
        int w;
        logic [11:0] full_tab [16];

        rst_n = 1'b0;
        start = 1'b0;
        addr  = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        m_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_dup", 32'(dup_err), 32'd0);
        check_table("rst_table");

        // Full load, in_valid held high, fixed leading targets then random ones.
        r_tgt[0] = 12'd0;  r_tgt[1] = 12'd37; r_tgt[2] = 12'd64; r_tgt[3] = 12'd72;
        r_tgt[4] = 12'd79; r_tgt[5] = 12'd16; r_tgt[6] = 12'd14; r_tgt[7] = 12'd1;
        r_tgt[8] = 12'd0;
        for (int i = 9; i < 16; i++) r_tgt[i] = 12'($urandom);
        do_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 16; i++) send_rec(4'(i), r_tgt[i], 0, 1'b1);
        addr = 4'd1; #1; chk("full_t1", 32'(target), 32'd37);
        addr = 4'd4; #1; chk("full_t4", 32'(target), 32'd79);
        chk("full_dup", 32'(dup_err), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);
        check_table("full_table");
        for (int i = 0; i < 16; i++) full_tab[i] = m_tab[i];

        // in_valid held high in DONE with junk data must not disturb anything.
        bus.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("done_hold_loaded", 32'(loaded), 32'd1);
        chk("done_hold_ready", 32'(bus.in_ready), 32'd0);
        check_table("done_hold_table");

        // Same records with random gaps must rebuild the identical table.
        do_start();
        check_table("reload_cleared");
        for (int i = 0; i < 16; i++) send_rec(4'(i), r_tgt[i], 3, 1'b0);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            chk("gap_vs_full", 32'(target), 32'(full_tab[i][D-1:0]));
        end

        // Shuffled order with gaps, record 3 = 0x3A,0xBC.
        do_start();
        shuffle_idx();
        for (int i = 0; i < 16; i++) begin
            logic [11:0] t;
            t = (r_idx[i] == 4'd3) ? 12'hABC : 12'($urandom);
            send_rec(r_idx[i], t, 2, 1'b0);
        end
        addr = 4'd3; #1; chk("rec_3ABC", 32'(target), 32'hABC);
        check_table("shuffle_table");

        // Duplicate index 5: 0x100 first, 0x0FF last, 14 unique others between.
        do_start();
        shuffle_idx();
        send_rec(4'd5, 12'h100, 1, 1'b0);
        begin
            int n;
            n = 0;
            for (int i = 0; i < 16 && n < 14; i++) begin
                if (r_idx[i] != 4'd5) begin
                    send_rec(r_idx[i], 12'($urandom), 1, 1'b0);
                    n++;
                end
            end
        end
        chk("dup_before", 32'(dup_err), 32'd0);
        chk("dup_not_loaded", 32'(loaded), 32'd0);
        send_rec(4'd5, 12'h0FF, 1, 1'b0);
        addr = 4'd5; #1; chk("dup_t5", 32'(target), 32'h0FF);
        chk("dup_flag", 32'(dup_err), 32'd1);
        chk("dup_loaded", 32'(loaded), 32'd1);
        check_table("dup_table");

        // Abort after byte0 of record 7; the byte offered with start must be dropped.
        do_start();
        chk("restart_dup_clr", 32'(dup_err), 32'd0);
        for (int i = 0; i < 7; i++) send_rec(4'(i), 12'($urandom_range(4095, 1)), 1, 1'b0);
        check_table("midload_table");
        offer(8'h7C, 0, w);
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hF5;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b0;
        m_clear();
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_loaded", 32'(loaded), 32'd0);
        check_table("abort_table");
        shuffle_idx();
        for (int i = 0; i < 16; i++) send_rec(r_idx[i], 12'($urandom), 1, 1'b0);
        chk("abort_reload_done", 32'(loaded), 32'd1);
        chk("abort_reload_dup", 32'(dup_err), 32'd0);
        check_table("abort_reload_table");

        // Asynchronous reset between edges while in LO.
        do_start();
        send_rec(4'd2, 12'h5A5, 0, 1'b0);
        send_rec(4'd9, 12'h3C3, 0, 1'b0);
        offer(8'h41, 0, w);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_clear();
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_loaded", 32'(loaded), 32'd0);
        addr = 4'd2; #1; chk("arst_t2", 32'(target), 32'd0);
        addr = 4'd9; #1; chk("arst_t9", 32'(target), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h21;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("post_arst_ready", 32'(bus.in_ready), 32'd0);
        chk("post_arst_busy", 32'(busy), 32'd0);
        chk("post_arst_loaded", 32'(loaded), 32'd0);
        check_table("post_arst_table");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
